// File: rtl/i2c_bus_arbiter_if.sv
// Signal bundle between the I2C channels, the shared-bus arbiter and the IOBUF pins.
// The slave modport is the arbiter's view; the master modport is the channel/board side.
interface i2c_bus_arbiter_if #(
  parameter int unsigned NUM_CHANNELS = 2
);
  localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [NUM_CHANNELS-1:0] request;
  logic [NUM_CHANNELS-1:0] grant;
  logic [NUM_CHANNELS-1:0] ch_scl_output;
  logic [NUM_CHANNELS-1:0] ch_sda_output;
  logic [NUM_CHANNELS-1:0] ch_scl_input;
  logic [NUM_CHANNELS-1:0] ch_sda_input;
  logic                    bus_scl_output;
  logic                    bus_sda_output;
  logic                    bus_scl_input;
  logic                    bus_sda_input;
  logic                    owner_valid;
  logic [IDX_W-1:0]        owner_index;
  logic [NUM_CHANNELS-1:0] timeout_status;
  logic [NUM_CHANNELS-1:0] timeout_clear;

  modport slave (
    input  request, ch_scl_output, ch_sda_output, bus_scl_input, bus_sda_input, timeout_clear,
    output grant, ch_scl_input, ch_sda_input, bus_scl_output, bus_sda_output,
           owner_valid, owner_index, timeout_status
  );

  modport master (
    output request, ch_scl_output, ch_sda_output, bus_scl_input, bus_sda_input, timeout_clear,
    input  grant, ch_scl_input, ch_sda_input, bus_scl_output, bus_sda_output,
           owner_valid, owner_index, timeout_status
  );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner selection for one shared I2C bus, with a forced-release guard time
// between owners and an optional hold timeout that revokes a grant and flags it.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned GUARD_CYCLES    = 1000,
  parameter int unsigned MAX_HOLD_CYCLES = 0
) (
  input  logic               system_clock,
  input  logic               system_reset_n,
  i2c_bus_arbiter_if.slave   arb
);

  localparam int unsigned IDX_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CNT_MAX = (GUARD_CYCLES > MAX_HOLD_CYCLES) ? GUARD_CYCLES : MAX_HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD_CYCLES == 0) ? 0 : MAX_HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  state_t                  r_state,       w_state_nxt;
  logic [NUM_CHANNELS-1:0] r_grant,       w_grant_nxt;
  logic [IDX_W-1:0]        r_owner,       w_owner_nxt;
  logic                    r_owner_valid, w_owner_valid_nxt;
  logic [IDX_W-1:0]        r_last,        w_last_nxt;
  logic [CNT_W-1:0]        r_cnt,         w_cnt_nxt;
  logic [NUM_CHANNELS-1:0] r_timeout,     w_timeout_nxt;

  logic                    w_hi_found;
  logic [IDX_W-1:0]        w_hi_idx;
  logic [IDX_W-1:0]        w_lo_idx;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_owner_req;

  // Round robin: lowest requester above the last owner, else lowest requester overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int c = int'(NUM_CHANNELS) - 1; c >= 0; c--) begin
      if (arb.request[IDX_W'(c)]) begin
        w_lo_idx = IDX_W'(c);
        if (IDX_W'(c) > r_last) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDX_W'(c);
        end
      end
    end
    w_pick_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  assign w_owner_req = arb.request[r_owner];

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_owner_valid <= 1'b0;
      r_last        <= LAST_RST;
      r_cnt         <= '0;
      r_timeout     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_owner_valid <= w_owner_valid_nxt;
      r_last        <= w_last_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  // Next-state logic; clear pulses apply first so a coincident timeout set wins.
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_owner_nxt       = r_owner;
    w_owner_valid_nxt = r_owner_valid;
    w_last_nxt        = r_last;
    w_cnt_nxt         = r_cnt;
    w_timeout_nxt     = r_timeout & ~arb.timeout_clear;

    case (r_state)
      ST_IDLE: begin
        if (|arb.request) begin
          w_state_nxt       = ST_GRANT;
          w_grant_nxt       = NUM_CHANNELS'(1'b1) << w_pick_idx;
          w_owner_nxt       = w_pick_idx;
          w_owner_valid_nxt = 1'b1;
          w_cnt_nxt         = '0;
        end
      end

      ST_GRANT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (!w_owner_req || ((MAX_HOLD_CYCLES != 0) && (r_cnt == HOLD_LAST))) begin
          if (w_owner_req) begin
            w_timeout_nxt[r_owner] = 1'b1;
          end
          w_state_nxt       = ST_GUARD;
          w_grant_nxt       = '0;
          w_owner_nxt       = '0;
          w_owner_valid_nxt = 1'b0;
          w_last_nxt        = r_owner;
          w_cnt_nxt         = '0;
        end
      end

      ST_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_grant_nxt       = '0;
        w_owner_nxt       = '0;
        w_owner_valid_nxt = 1'b0;
        w_cnt_nxt         = '0;
      end
    endcase
  end

  // Bus drive follows only the registered owner, so reset releases the pins without a clock.
  assign arb.bus_scl_output = r_owner_valid ? arb.ch_scl_output[r_owner] : 1'b1;
  assign arb.bus_sda_output = r_owner_valid ? arb.ch_sda_output[r_owner] : 1'b1;

  assign arb.ch_scl_input   = {NUM_CHANNELS{arb.bus_scl_input}};
  assign arb.ch_sda_input   = {NUM_CHANNELS{arb.bus_sda_input}};

  assign arb.grant          = r_grant;
  assign arb.owner_valid    = r_owner_valid;
  assign arb.owner_index    = r_owner;
  assign arb.timeout_status = r_timeout;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: two configurations (N=2 with hold timeout, N=3 unlimited)
// compared each cycle against an abstract owner/guard/round-robin model.
module tb_i2c_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_bus_arbiter_if #(.NUM_CHANNELS(2)) arb_a ();
  i2c_bus_arbiter_if #(.NUM_CHANNELS(3)) arb_b ();

  i2c_bus_arbiter #(.NUM_CHANNELS(2), .GUARD_CYCLES(10), .MAX_HOLD_CYCLES(50)) dut_a (
    .system_clock(clk), .system_reset_n(rst_n), .arb(arb_a));
  i2c_bus_arbiter #(.NUM_CHANNELS(3), .GUARD_CYCLES(3), .MAX_HOLD_CYCLES(0)) dut_b (
    .system_clock(clk), .system_reset_n(rst_n), .arb(arb_b));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner (-1 = none), cycles held, guard cycles left, last owner, flags.
  int NCH [2] = '{2, 3};
  int GRD [2] = '{10, 3};
  int MXH [2] = '{50, 0};
  int m_owner [2];
  int m_held  [2];
  int m_guard [2];
  int m_last  [2];
  logic [2:0] m_tmo [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_held[k]  = 0;
      m_guard[k] = 0;
      m_last[k]  = NCH[k] - 1;
      m_tmo[k]   = 3'b000;
    end
  endtask

  task automatic model_release(input int k);
    m_last[k]  = m_owner[k];
    m_owner[k] = -1;
    m_guard[k] = GRD[k];
  endtask

  task automatic model_step(input int k, input logic [2:0] req, input logic [2:0] clr);
    logic [2:0] setb;
    setb = 3'b000;
    if (m_owner[k] >= 0) begin
      m_held[k]++;
      if (((req >> m_owner[k]) & 3'd1) == 3'd0) begin
        model_release(k);
      end else if (MXH[k] != 0 && m_held[k] == MXH[k]) begin
        setb = 3'(1) << m_owner[k];
        model_release(k);
      end
    end else if (m_guard[k] > 0) begin
      m_guard[k]--;
    end else begin
      for (int i = 1; i <= NCH[k]; i++) begin
        int c;
        c = (m_last[k] + i) % NCH[k];
        if (m_owner[k] < 0 && ((req >> c) & 3'd1) != 3'd0) begin
          m_owner[k] = c;
          m_held[k]  = 0;
        end
      end
    end
    m_tmo[k] = (m_tmo[k] & ~clr) | setb;
  endtask

  function automatic logic [31:0] m_grant(input int k);
    return (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0;
  endfunction

  function automatic logic [31:0] m_bus(input int k, input logic [31:0] drv);
    return (m_owner[k] >= 0) ? ((drv >> m_owner[k]) & 32'd1) : 32'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      model_step(0, {1'b0, arb_a.request}, {1'b0, arb_a.timeout_clear});
      model_step(1, arb_b.request, arb_b.timeout_clear);
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_grant",       32'(arb_a.grant),          m_grant(0));
      chk("a_owner_valid", 32'(arb_a.owner_valid),    32'((m_owner[0] >= 0) ? 1 : 0));
      chk("a_owner_index", 32'(arb_a.owner_index),    32'((m_owner[0] >= 0) ? m_owner[0] : 0));
      chk("a_bus_scl",     32'(arb_a.bus_scl_output), m_bus(0, 32'(arb_a.ch_scl_output)));
      chk("a_bus_sda",     32'(arb_a.bus_sda_output), m_bus(0, 32'(arb_a.ch_sda_output)));
      chk("a_ch_scl_in",   32'(arb_a.ch_scl_input),   arb_a.bus_scl_input ? 32'h3 : 32'h0);
      chk("a_ch_sda_in",   32'(arb_a.ch_sda_input),   arb_a.bus_sda_input ? 32'h3 : 32'h0);
      chk("a_timeout",     32'(arb_a.timeout_status), 32'(m_tmo[0]));
      chk("b_grant",       32'(arb_b.grant),          m_grant(1));
      chk("b_owner_valid", 32'(arb_b.owner_valid),    32'((m_owner[1] >= 0) ? 1 : 0));
      chk("b_owner_index", 32'(arb_b.owner_index),    32'((m_owner[1] >= 0) ? m_owner[1] : 0));
      chk("b_bus_scl",     32'(arb_b.bus_scl_output), m_bus(1, 32'(arb_b.ch_scl_output)));
      chk("b_bus_sda",     32'(arb_b.bus_sda_output), m_bus(1, 32'(arb_b.ch_sda_output)));
      chk("b_ch_scl_in",   32'(arb_b.ch_scl_input),   arb_b.bus_scl_input ? 32'h7 : 32'h0);
      chk("b_ch_sda_in",   32'(arb_b.ch_sda_input),   arb_b.bus_sda_input ? 32'h7 : 32'h0);
      chk("b_timeout",     32'(arb_b.timeout_status), 32'(m_tmo[1]));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant_a(input logic [1:0] exp);
    int n;
    n = 0;
    while (arb_a.grant !== exp && n < 100) begin
      next_cycle();
      n++;
    end
    chk("a_wait_grant", 32'(arb_a.grant), 32'(exp));
  endtask

  task automatic wait_grant_b();
    int n;
    n = 0;
    while (arb_b.grant === 3'b000 && n < 100) begin
      next_cycle();
      n++;
    end
    chk("b_wait_grant", 32'(|arb_b.grant), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [5] = '{0, 1, 2, 0, 1};

    arb_a.request = '0; arb_a.ch_scl_output = '1; arb_a.ch_sda_output = '1;
    arb_a.bus_scl_input = 1'b1; arb_a.bus_sda_input = 1'b1; arb_a.timeout_clear = '0;
    arb_b.request = '0; arb_b.ch_scl_output = '1; arb_b.ch_sda_output = '1;
    arb_b.bus_scl_input = 1'b1; arb_b.bus_sda_input = 1'b1; arb_b.timeout_clear = '0;

    // Reset values
    repeat (3) next_cycle();
    chk("rst_a_grant",   32'(arb_a.grant),          32'h0);
    chk("rst_a_valid",   32'(arb_a.owner_valid),    32'h0);
    chk("rst_a_index",   32'(arb_a.owner_index),    32'h0);
    chk("rst_a_bus_scl", 32'(arb_a.bus_scl_output), 32'h1);
    chk("rst_a_timeout", 32'(arb_a.timeout_status), 32'h0);
    chk("rst_b_grant",   32'(arb_b.grant),          32'h0);
    rst_n = 1'b1;

    // Both channels request: channel 0 wins one edge later
    arb_a.request = 2'b11;
    next_cycle(); #1;
    chk("t1_grant", 32'(arb_a.grant),       32'h1);
    chk("t1_index", 32'(arb_a.owner_index), 32'h0);
    chk("t1_valid", 32'(arb_a.owner_valid), 32'h1);
    chk("t1_model_owner", 32'(m_owner[0]),  32'h0);

    // Drop ch0 after edge 10: grant low for GUARD_CYCLES+1 cycles, bus released throughout
    repeat (9) next_cycle();
    chk("t2_still_granted", 32'(arb_a.grant), 32'h1);
    arb_a.request = 2'b10;
    arb_a.ch_scl_output = 2'b00;
    arb_a.ch_sda_output = 2'b00;
    for (int i = 0; i <= 10; i++) begin
      next_cycle(); #1;
      chk("t2_guard_grant", 32'(arb_a.grant),          32'h0);
      chk("t2_guard_scl",   32'(arb_a.bus_scl_output), 32'h1);
      chk("t2_guard_sda",   32'(arb_a.bus_sda_output), 32'h1);
    end
    next_cycle(); #1;
    chk("t2_grant_ch1", 32'(arb_a.grant),       32'h2);
    chk("t2_index_ch1", 32'(arb_a.owner_index), 32'h1);

    // Only the owner's drive reaches the bus; inputs are fanned out ungated
    arb_a.ch_scl_output = 2'b01;
    arb_a.ch_sda_output = 2'b10;
    arb_a.bus_scl_input = 1'b0;
    arb_a.bus_sda_input = 1'b1;
    #1;
    chk("t3_bus_scl",   32'(arb_a.bus_scl_output), 32'h0);
    chk("t3_bus_sda",   32'(arb_a.bus_sda_output), 32'h1);
    chk("t3_ch_scl_in", 32'(arb_a.ch_scl_input),   32'h0);
    chk("t3_ch_sda_in", 32'(arb_a.ch_sda_input),   32'h3);
    arb_a.bus_scl_input = 1'b1;
    arb_a.bus_sda_input = 1'b0;
    #1;
    chk("t3_ch_scl_in2", 32'(arb_a.ch_scl_input), 32'h3);
    chk("t3_ch_sda_in2", 32'(arb_a.ch_sda_input), 32'h0);
    arb_a.ch_scl_output = 2'b11;
    arb_a.ch_sda_output = 2'b11;
    arb_a.bus_sda_input = 1'b1;

    // Hold timeout: 50 granted cycles, then revoked and flagged
    arb_a.request = 2'b00;
    next_cycle();
    arb_a.request = 2'b01;
    wait_grant_a(2'b01);
    repeat (49) next_cycle();
    chk("t4_grant_49", 32'(arb_a.grant), 32'h1);
    next_cycle(); #1;
    chk("t4_grant_revoked", 32'(arb_a.grant),          32'h0);
    chk("t4_flag_set",      32'(arb_a.timeout_status), 32'h1);
    chk("t4_model_flag",    32'(m_tmo[0]),             32'h1);
    arb_a.timeout_clear = 2'b01;
    next_cycle();
    arb_a.timeout_clear = 2'b00; #1;
    chk("t4_flag_cleared", 32'(arb_a.timeout_status), 32'h0);

    // Clear coinciding with a new timeout: set wins
    wait_grant_a(2'b01);
    repeat (49) next_cycle();
    arb_a.timeout_clear = 2'b01;
    next_cycle();
    arb_a.timeout_clear = 2'b00; #1;
    chk("t4_set_wins",      32'(arb_a.timeout_status), 32'h1);
    chk("t4_set_wins_gnt",  32'(arb_a.grant),          32'h0);
    arb_a.timeout_clear = 2'b01;
    next_cycle();
    arb_a.timeout_clear = 2'b00; #1;
    chk("t4_flag_cleared2", 32'(arb_a.timeout_status), 32'h0);

    // Request dropping on the timeout cycle is a normal release
    wait_grant_a(2'b01);
    repeat (49) next_cycle();
    arb_a.request = 2'b00;
    next_cycle(); #1;
    chk("t4_drop_grant", 32'(arb_a.grant),          32'h0);
    chk("t4_drop_noflag", 32'(arb_a.timeout_status), 32'h0);

    // N=3 round-robin order with each owner releasing after 5 cycles
    arb_b.request = 3'b111;
    for (int k = 0; k < 5; k++) begin
      wait_grant_b();
      chk("t5_order_index", 32'(arb_b.owner_index), 32'(ord[k]));
      chk("t5_order_grant", 32'(arb_b.grant),       32'd1 << ord[k]);
      repeat (4) next_cycle();
      arb_b.request = arb_b.request & ~(3'(1) << ord[k]);
      next_cycle();
      arb_b.request = arb_b.request | (3'(1) << ord[k]);
    end

    // Reset mid-grant releases grant and bus without a clock edge
    wait_grant_b();
    chk("t5_next_is_2", 32'(arb_b.owner_index), 32'h2);
    arb_b.ch_scl_output = 3'b000;
    arb_b.ch_sda_output = 3'b000;
    #1;
    chk("t6_pre_scl", 32'(arb_b.bus_scl_output), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(arb_b.grant),          32'h0);
    chk("t6_rst_scl",   32'(arb_b.bus_scl_output), 32'h1);
    chk("t6_rst_sda",   32'(arb_b.bus_sda_output), 32'h1);
    chk("t6_rst_valid", 32'(arb_b.owner_valid),    32'h0);
    arb_b.request = 3'b000;
    arb_b.ch_scl_output = 3'b111;
    arb_b.ch_sda_output = 3'b111;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    arb_b.request = 3'b100;
    next_cycle(); #1;
    chk("t6_grant_ch2", 32'(arb_b.grant),       32'h4);
    chk("t6_index_ch2", 32'(arb_b.owner_index), 32'h2);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 29) == 0) arb_a.request = arb_a.request ^ (2'(1) << i);
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 19) == 0) arb_b.request = arb_b.request ^ (3'(1) << i);
      arb_a.ch_scl_output = 2'($urandom);
      arb_a.ch_sda_output = 2'($urandom);
      arb_b.ch_scl_output = 3'($urandom);
      arb_b.ch_sda_output = 3'($urandom);
      arb_a.bus_scl_input = 1'($urandom);
      arb_a.bus_sda_input = 1'($urandom);
      arb_b.bus_scl_input = 1'($urandom);
      arb_b.bus_sda_input = 1'($urandom);
      arb_a.timeout_clear = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      arb_b.timeout_clear = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
    end
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
